// File: rtl/apb_mem_slave_if.sv
// APB4 bus bundle between a master (interconnect, bridge, bench) and apb_mem_slave.
interface apb_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic                pready;
  logic [DATA_W-1:0]   prdata;
  logic                pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB4 slave with a word-addressed RAM, byte strobes, programmable wait states and base decode.
// Define APB_SLV_ERR_EN to drive pslverr on out-of-range or misaligned accesses; otherwise it is tied to 0.
module apb_mem_slave #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rstn,
  apb_mem_slave_if.slave   apb_s
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                write_q;
  logic                err_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   off;
  logic [ADDR_W-1:0]   word;
  logic                dec_err;
  logic [IDX_W-1:0]    dec_idx;
  logic                setup;
  logic                complete;
  logic                pready_int;

  // Subtraction wraps on underflow, so addresses below BASE_ADDR land out of range.
  always_comb begin
    off     = apb_s.paddr - BASE_ADDR;
    word    = off >> LSB;
    dec_err = ((off & ALIGN_MASK) != '0) || (word >= ADDR_W'(DEPTH));
    dec_idx = word[IDX_W-1:0];
  end

  assign setup      = rstn && (state_q == IDLE) && apb_s.psel;
  assign pready_int = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign complete   = rstn && pready_int && apb_s.psel && apb_s.penable;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (apb_s.psel) begin
            write_q <= apb_s.pwrite;
            err_q   <= dec_err;
            idx_q   <= dec_idx;
            wdata_q <= apb_s.pwdata;
            strb_q  <= apb_s.pstrb;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!apb_s.psel) begin
            state_q <= IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (apb_s.penable) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage has no reset; the read register is gated at the output instead.
  always_ff @(posedge clk) begin
    if (complete && write_q && !err_q) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
    if (setup && !apb_s.pwrite) begin
      rdata_q <= mem[dec_idx];
    end
  end

  assign apb_s.pready = pready_int;
  assign apb_s.prdata = (pready_int && !write_q && !err_q) ? rdata_q : '0;

`ifdef APB_SLV_ERR_EN
  assign apb_s.pslverr = pready_int && err_q;
`else
  assign apb_s.pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: one instance with no wait states, one with three.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

`ifdef APB_SLV_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  assign bus0.paddr   = paddr;
  assign bus0.psel    = psel & ~sel;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;
  assign bus3.paddr   = paddr;
  assign bus3.psel    = psel & sel;
  assign bus3.penable = penable;
  assign bus3.pwrite  = pwrite;
  assign bus3.pwdata  = pwdata;
  assign bus3.pstrb   = pstrb;

  assign pready  = sel ? bus3.pready  : bus0.pready;
  assign prdata  = sel ? bus3.prdata  : bus0.prdata;
  assign pslverr = sel ? bus3.pslverr : bus0.pslverr;

  apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0))
    dut0 (.clk(clk), .rstn(rstn), .apb_s(bus0));
  apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(3))
    dut3 (.clk(clk), .rstn(rstn), .apb_s(bus3));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Setup then access; returns the data and error seen on the pready cycle.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er,
                      output int waits);
    paddr = a; pwrite = wr; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 50) begin
      check("wait_prdata", 64'(prdata), 64'h0);
      @(posedge clk); #1;
      waits++;
    end
    check("timeout", 64'(pready), 64'h1);
    rd = prdata; er = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          w;
  int          c0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0;
    check("rst_pready0", 64'(pready), 64'h0);
    check("rst_prdata0", 64'(prdata), 64'h0);
    check("rst_pslverr0", 64'(pslverr), 64'h0);
    sel = 1'b1;
    check("rst_pready3", 64'(pready), 64'h0);
    rstn = 1'b1;
    sel = 1'b0;
    @(posedge clk); #1;

    // 1: basic write / read
    xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd, er, w);
    check("t1_wr_waits", 64'(w), 64'd0);
    check("t1_wr_err", 64'(er), 64'h0);
    xfer(32'h10, 1'b0, 32'h0, 4'h0, rd, er, w);
    check("t1_rd_waits", 64'(w), 64'd0);
    check("t1_rd_data", 64'(rd), 64'hDEADBEEF);
    check("t1_rd_err", 64'(er), 64'h0);
    check("t1_idle_prdata", 64'(prdata), 64'h0);

    // 2: byte strobes
    xfer(32'h20, 1'b1, 32'h11223344, 4'hF, rd, er, w);
    xfer(32'h20, 1'b1, 32'hAABBCCDD, 4'h5, rd, er, w);
    xfer(32'h20, 1'b0, 32'h0, 4'h0, rd, er, w);
    check("t2_strb", 64'(rd), 64'h11BB33DD);

    // 3: wait states
    sel = 1'b1;
    xfer(32'h04, 1'b1, 32'h0BADCAFE, 4'hF, rd, er, w);
    check("t3_wr_waits", 64'(w), 64'd3);
    xfer(32'h04, 1'b0, 32'h0, 4'h0, rd, er, w);
    check("t3_rd_waits", 64'(w), 64'd3);
    check("t3_rd_data", 64'(rd), 64'h0BADCAFE);
    check("t3_after_prdata", 64'(prdata), 64'h0);

    // 4: error accesses
    sel = 1'b0;
    xfer(32'h00, 1'b1, 32'h5A5A5A5A, 4'hF, rd, er, w);
    xfer(32'h400, 1'b0, 32'h0, 4'h0, rd, er, w);
    check("t4_oor_err", 64'(er), 64'(EXP_ERR));
    check("t4_oor_data", 64'(rd), 64'h0);
    xfer(32'h02, 1'b1, 32'hFFFFFFFF, 4'hF, rd, er, w);
    check("t4_unal_err", 64'(er), 64'(EXP_ERR));
    check("t4_unal_waits", 64'(w), 64'd0);
    xfer(32'h00, 1'b0, 32'h0, 4'h0, rd, er, w);
    check("t4_mem0", 64'(rd), 64'h5A5A5A5A);
    check("t4_ok_err", 64'(er), 64'h0);

    // 5: reset during a waited write
    sel = 1'b1;
    xfer(32'h08, 1'b1, 32'h55667788, 4'hF, rd, er, w);
    paddr = 32'h08; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("t5_pre_pready", 64'(pready), 64'h0);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("t5_rst_pready", 64'(pready), 64'h0);
    psel = 1'b0; penable = 1'b0; rstn = 1'b1;
    @(posedge clk); #1;
    check("t5_post_pready", 64'(pready), 64'h0);
    xfer(32'h08, 1'b0, 32'h0, 4'h0, rd, er, w);
    check("t5_mem8", 64'(rd), 64'h55667788);
    check("t5_waits", 64'(w), 64'd3);

    // 6: back-to-back burst, two cycles per transfer
    sel = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 16; i++)
      xfer(32'(i * 4), 1'b1, 32'h10000000 + 32'(i) * 32'h01010101, 4'hF, rd, er, w);
    check("t6_wr_cycles", 64'(cyc - c0), 64'd32);
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      xfer(32'(i * 4), 1'b0, 32'h0, 4'h0, rd, er, w);
      check($sformatf("t6_rd%0d", i), 64'(rd), 64'(32'h10000000 + 32'(i) * 32'h01010101));
    end
    check("t6_rd_cycles", 64'(cyc - c0), 64'd32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB4 memory-mapped slave with a word-addressed RAM behind it, for peripheral and bridge testbenches and for simple register/scratch storage.
- Adds over the previous APB slave: configurable width and depth, byte strobes, programmable wait states, base-address decode, and pslverr on bad accesses.
- Sits behind an APB interconnect or a WB-to-APB bridge.

Parameters:
ADDR_W, 32, paddr width
DATA_W, 32, data width; multiple of 8, at most 64
DEPTH, 256, number of DATA_W words in storage
BASE_ADDR, 0, byte address of word 0; aligned to DATA_W/8
WAIT_CYCLES, 0, extra access-phase cycles before pready (0..15)

Ports:
clk  in  1  clock, all logic on posedge
rstn  in  1  reset, synchronous, active-low
paddr  in  ADDR_W  byte address
psel  in  1  slave select
penable  in  1  access phase
pwrite  in  1  1=write, 0=read
pwdata  in  DATA_W  write data
pstrb  in  DATA_W/8  write byte strobes
pready  out  1  transfer complete
prdata  out  DATA_W  read data, valid only while pready=1 on a read
pslverr  out  1  error response, valid only while pready=1

Behaviour:
- FSM states: IDLE, ACCESS.
- Reset (rstn=0 at posedge):
  - State goes to IDLE; wait counter 0.
  - pready=0, pslverr=0, prdata=0 from the next cycle.
  - RAM contents are not reset.
- Decode, computed in IDLE:
  - off = paddr - BASE_ADDR, ADDR_W-bit unsigned; underflow wraps to a large value and is out of range.
  - idx = off >> log2(DATA_W/8).
  - err = (off low log2(DATA_W/8) bits != 0) || (idx >= DEPTH).
- IDLE:
  - If psel=1, capture pwrite, idx, err, pwdata and pstrb; load counter with WAIT_CYCLES; go to ACCESS.
  - For a read, also capture the read word (mem[idx], or 0 if err) into the read register.
  - penable is ignored here; psel with penable=1 in IDLE is treated as a setup.
- ACCESS:
  - pready = (counter==0), combinational from state and counter.
  - While counter>0 and psel=1: decrement counter.
  - At the posedge with counter==0, psel=1 and penable=1: complete the transfer and go to IDLE.
  - On a write with err=0, that completing edge writes mem[idx] byte lane b only where pstrb[b]=1.
  - A write with err=1 never modifies memory.
  - psel=0 in ACCESS is an aborted transfer: go to IDLE, no write, no error.
- Outputs:
  - prdata = captured read word when pready=1 and the transfer is a read; otherwise 0.
  - pslverr = err when pready=1; otherwise 0.
  - pstrb is ignored on reads.
- Latency:
  - WAIT_CYCLES=0: standard 2-cycle transfer, pready=1 in the first access cycle.
  - Otherwise pready rises after WAIT_CYCLES access cycles.
- Back-to-back:
  - After completion the FSM is in IDLE on the next cycle and accepts a new setup immediately; no dead cycle beyond the APB setup phase.
  - A read following a write to the same address returns the new data, because capture happens after the write edge.
- Reset mid-operation:
  - Return to IDLE, drop the pending transfer, no memory write.
  - pready stays 0 until a new setup phase.

Optional Feature:
APB_SLV_ERR_EN
- Defined: pslverr is driven as above.
- Undefined: pslverr is tied to 0. Erroneous writes are still silently dropped and erroneous reads still return 0; pready timing is unchanged.

Test Plan:
1. Write 0xDEADBEEF to 0x10 with pstrb=0xF, WAIT_CYCLES=0, then read 0x10 -> each transfer completes in 2 cycles; prdata=0xDEADBEEF; pslverr=0.
2. Preload 0x11223344 at 0x20, write 0xAABBCCDD with pstrb=0x5, read 0x20 -> prdata=0x11BB33DD.
3. WAIT_CYCLES=3, read 0x04 -> pready low for exactly 3 access cycles, high on the 4th; prdata valid only on that cycle.
4. Read 0x400 (idx 256 >= DEPTH) and write to unaligned 0x02 -> pready with pslverr=1, prdata=0; memory at 0x00 unchanged. With APB_SLV_ERR_EN undefined, pslverr=0 and the same memory result.
5. Assert rstn=0 during a WAIT_CYCLES=3 write to 0x08 after 1 access cycle -> pready=0; mem at 0x08 keeps its old value; the next transfer works normally.
6. Back-to-back writes to 0x00..0x3C, then reads in the same order -> all 16 values match; no idle cycles between transfers beyond setup.
